mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port MemReadWrite block between two requesters: the CPU
//  control FSM (instruction fetch, lw, sw) and the debug/inference readout path.
//  Sits between ControlUnit and MemReadWrite, owns all mem_* strobes and
//  sequences each access through the memory's fixed read latency.
//  Round-robin arbitration; req/ack handshake per requester.
// PARAMETERS
//  AW      16  memory address width (matches MemReadWrite addr)
//  DW      32  data width
//  RD_LAT  3   cycles mem_en/mem_ren are held before mem_dout is sampled; >=1
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-high
//  cpu_req    in   1   CPU access request; hold with fields stable until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_ack    out  1   1-cycle pulse: access complete
//  cpu_rdata  out  DW  read data, valid with cpu_ack, held until next CPU read ack
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack/dbg_rdata  same set for debug port
//  mem_en     out  1   to MemReadWrite en
//  mem_ren    out  1   to MemReadWrite ren
//  mem_wen    out  1   to MemReadWrite wen
//  mem_addr   out  AW  to MemReadWrite addr
//  mem_din    out  DW  to MemReadWrite din
//  mem_dout   in   DW  from MemReadWrite dout
//  busy       out  1   1 when state != IDLE
//  owner      out  1   0 = CPU, 1 = DBG; port of the current/last grant
// BEHAVIOUR
//  Reset: all outputs 0 (owner=0); state IDLE; last-served pointer = DBG so the
//   CPU wins the first contention; RD counter 0. Reset mid-access aborts it: no ack.
//  FSM: IDLE -> ISSUE -> (we ? ACK : WAIT) ; WAIT -> ACK after RD_LAT cycles; ACK -> IDLE.
//  IDLE: sample reqs. One req -> grant it. Both -> grant port != last-served.
//   On grant latch we/addr/wdata into internal regs, set owner, update last-served.
//  ISSUE (1 cycle): mem_en=1, mem_addr/mem_din from latched regs;
//   write: mem_wen=1, mem_ren=0; read: mem_ren=1, mem_wen=0.
//  WAIT (reads only): mem_en=mem_ren=1, addr held; counter 1..RD_LAT;
//   on last WAIT cycle register mem_dout into owner's rdata.
//  ACK (1 cycle): all mem_* strobes 0, owner's ack=1, other ack=0.
//  Latency from req sampled in IDLE (cycle 0): write ack at cycle 2;
//   read ack at cycle RD_LAT+2 (5 for default). Throughput: one access per
//   3 (write) / RD_LAT+3 (read) cycles; no back-to-back without IDLE.
//  Requester must drop req in the cycle after ack; a req still high in IDLE is
//   a new request. req dropped mid-access: ignored, access completes, ack pulses.
//  Latched fields, not live inputs, drive memory; input changes mid-access ignored.
//  Loser of contention keeps req high and is granted at the next IDLE (no starvation:
//   max wait = one other-port access).
//  mem_addr/mem_din hold last values in IDLE/ACK; only strobes return to 0.
//  Non-owner rdata never changes; acks never both high.
// TESTING
//  1 Reset mid-read (assert reset in WAIT) -> strobes 0 same cycle, no cpu_ack, busy=0.
//  2 cpu write addr=0x0010 data=0xDEADBEEF -> ISSUE mem_en=1 mem_wen=1 at cycle 1, cpu_ack cycle 2.
//  3 dbg read addr=0x189C, mem model returns 0x00001234 -> mem_ren high cycles 1..4,
//    dbg_ack at cycle 5, dbg_rdata=0x00001234, cpu_rdata unchanged.
//  4 cpu_req and dbg_req same cycle after reset -> CPU served first, then DBG; repeat
//    contention -> grants alternate CPU,DBG,CPU,DBG.
//  5 Change cpu_addr 0x0020->0x0030 during WAIT -> mem_addr stays 0x0020 through ACK.
//  6 RD_LAT=1 build, cpu read -> ack at cycle 3 with correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between CPU and debug requesters
//   clk, reset                      clock, async active-high reset
//   cpu_req/we/addr/wdata -> ack/rdata   CPU access port (req held until ack)
//   dbg_req/we/addr/wdata -> ack/rdata   debug readout port (same handshake)
//   mem_en/ren/wen/addr/din, mem_dout    MemReadWrite interface, reads sampled after RD_LAT cycles
//   busy                            access in progress
//   owner                           port of the current/last grant (0 = CPU, 1 = DBG)
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          owner
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;
    localparam int CW = $clog2(RD_LAT + 1);
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last_dbg;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          gnt_dbg;
    // debug wins only when it is alone or the CPU was served last
    assign gnt_dbg = dbg_req & (~cpu_req | ~last_dbg);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_dbg  <= 1'b1;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_req | dbg_req) begin
                    state    <= ISSUE;
                    owner    <= gnt_dbg;
                    last_dbg <= gnt_dbg;
                    we_q     <= gnt_dbg ? dbg_we : cpu_we;
                    addr_q   <= gnt_dbg ? dbg_addr : cpu_addr;
                    wdata_q  <= gnt_dbg ? dbg_wdata : cpu_wdata;
                end
                ISSUE: begin
                    state <= we_q ? ACK : WAIT;
                    cnt   <= CW'(1);
                end
                WAIT: if (cnt == CW'(RD_LAT)) begin
                    state <= ACK;
                    if (owner) dbg_rdata <= mem_dout;
                    else cpu_rdata <= mem_dout;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // strobes decode straight from state so an async reset drops them in the same cycle
    assign mem_en   = (state == ISSUE) || (state == WAIT);
    assign mem_ren  = mem_en & ~we_q;
    assign mem_wen  = (state == ISSUE) & we_q;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign busy     = state != IDLE;
    assign cpu_ack  = (state == ACK) & ~owner;
    assign dbg_ack  = (state == ACK) & owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a 4K-word memory reference
module tb_mem_port_arbiter;
    localparam int RD_LAT = 3;
    typedef struct packed {
        logic        we;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] r;
    } txn_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] cpu_addr = '0, dbg_addr = '0;
    logic [31:0] cpu_wdata = '0, dbg_wdata = '0;
    logic        cpu_ack, dbg_ack, mem_en, mem_ren, mem_wen, busy, owner;
    logic [31:0] cpu_rdata, dbg_rdata, mem_din;
    logic [15:0] mem_addr;
    logic [31:0] mem_dout = '0;
    int cmp = 0;
    int mism = 0;
    txn_t q0[$];
    txn_t q1[$];
    bit ack_order[$];
    logic [31:0] exp_last [2];
    logic [31:0] done_last [2];
    logic [31:0] shadow [logic [11:0]];

    mem_port_arbiter #(.AW(16), .DW(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy), .owner(owner)
    );

    // second instance built with the shortest read latency
    logic        c1_req = 1'b0, d1_req = 1'b0, d1_we = 1'b0, c1_we = 1'b0;
    logic [15:0] c1_addr = '0, d1_addr = '0;
    logic [31:0] c1_wdata = '0, d1_wdata = '0;
    logic        c1_ack, d1_ack, m1_en, m1_ren, m1_wen, busy1, owner1;
    logic [31:0] c1_rdata, d1_rdata, m1_din;
    logic [15:0] m1_addr;
    logic [31:0] m1_dout = '0;
    mem_port_arbiter #(.AW(16), .DW(32), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
        .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
        .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
        .dbg_ack(d1_ack), .dbg_rdata(d1_rdata),
        .mem_en(m1_en), .mem_ren(m1_ren), .mem_wen(m1_wen), .mem_addr(m1_addr),
        .mem_din(m1_din), .mem_dout(m1_dout), .busy(busy1), .owner(owner1)
    );
    always @(posedge clk) if (m1_en && m1_ren) m1_dout <= {16'hC0DE, m1_addr};

    // memory model: registered read, contents preset on reset
    function automatic logic [31:0] init_val(input logic [11:0] i);
        return (i == 12'h89C) ? 32'h0000_1234 : {4'h0, ~i, 4'h0, i};
    endfunction
    logic [31:0] mem_arr [0:4095];
    logic        prev_en = 1'b0, acc_we = 1'b0, acc_bad = 1'b0;
    logic [15:0] acc_addr = '0;
    logic [31:0] acc_din = '0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= init_val(12'(i));
        end else if (mem_en) begin
            if (mem_wen) mem_arr[mem_addr[11:0]] <= mem_din;
            if (mem_ren) mem_dout <= mem_arr[mem_addr[11:0]];
            acc_bad  <= prev_en && (acc_bad || mem_addr != acc_addr);
            acc_addr <= mem_addr;
            acc_we   <= mem_wen;
            acc_din  <= mem_din;
        end
        prev_en <= mem_en;
    end

    function automatic logic [31:0] sval(input logic [15:0] a);
        return shadow.exists(a[11:0]) ? shadow[a[11:0]] : init_val(a[11:0]);
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic drive(input bit p, input bit rq, input bit we, input logic [15:0] a, input logic [31:0] d);
        if (p) begin dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else begin cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    task automatic issue(input bit p, input bit we, input logic [15:0] a, input logic [31:0] d, input bit push);
        txn_t e;
        e.we = we; e.a = a; e.d = d;
        if (we) begin
            shadow[a[11:0]] = d;
            e.r = exp_last[p];
        end else begin
            e.r = sval(a);
            exp_last[p] = e.r;
        end
        if (push) begin
            if (p) q1.push_back(e);
            else q0.push_back(e);
        end
        drive(p, 1'b1, we, a, d);
    endtask

    task automatic wait_ack(input bit p);
        int n = 0;
        @(negedge clk);
        while (!(p ? dbg_ack : cpu_ack) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            cmp++; mism++;
            $display("FAIL ack_timeout port %0d: no ack after %0d cycles, expected ack", p, n);
        end
        if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
    endtask

    // single access with cycle-by-cycle strobe checks; a_mid is put on the port's address in cycle 2
    task automatic run(input bit p, input bit we, input logic [15:0] a, input logic [31:0] d, input logic [15:0] a_mid);
        int lat = we ? 2 : RD_LAT + 2;
        issue(p, we, a, d, 1'b1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 2) begin
                if (p) dbg_addr = a_mid; else cpu_addr = a_mid;
            end
            if (c < lat) begin
                chk("run_mem_en", mem_en, 1);
                chk("run_mem_ren", mem_ren, !we);
                chk("run_mem_wen", mem_wen, we);
                chk("run_mem_addr", mem_addr, a);
                if (we) chk("run_mem_din", mem_din, d);
                chk("run_no_early_ack", {cpu_ack, dbg_ack}, 0);
            end else begin
                chk("run_ack", p ? dbg_ack : cpu_ack, 1);
                chk("run_ack_strobes_off", {mem_en, mem_ren, mem_wen}, 0);
                chk("run_addr_hold", mem_addr, a);
            end
        end
        if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_port(input bit p);
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [15:0] a;
            logic [31:0] d;
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            a  = {p ? 8'h18 : 8'h00, 4'h0, 4'($urandom_range(0, 15))};
            issue(p, we, a, d, 1'b1);
            wait_ack(p);
        end
    endtask

    // monitor: pops the acking port's expectation and compares
    initial begin
        txn_t e;
        bit   p;
        forever begin
            @(negedge clk);
            if (!reset && (cpu_ack || dbg_ack)) begin
                p = dbg_ack;
                ack_order.push_back(p);
                chk("ack_exclusive", {cpu_ack, dbg_ack}, p ? 2'b01 : 2'b10);
                if ((p ? q1.size() : q0.size()) == 0) begin
                    cmp++; mism++;
                    $display("FAIL unexpected_ack port %0d: ack with nothing outstanding, expected no ack", p);
                end else begin
                    if (p) e = q1.pop_front(); else e = q0.pop_front();
                    chk("owner", owner, p);
                    chk("rdata", p ? dbg_rdata : cpu_rdata, e.r);
                    chk("other_rdata", p ? cpu_rdata : dbg_rdata, done_last[~p]);
                    chk("mem_addr_used", acc_addr, e.a);
                    chk("mem_we_used", acc_we, e.we);
                    chk("addr_stable", acc_bad, 0);
                    if (e.we) chk("mem_din_used", acc_din, e.d);
                    done_last[p] = e.r;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit exp_order [4];
        exp_last[0] = '0; exp_last[1] = '0; done_last[0] = '0; done_last[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {mem_en, mem_ren, mem_wen}, 0);
        chk("rst_acks", {cpu_ack, dbg_ack}, 0);
        chk("rst_busy_owner", {busy, owner}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);
        // reset during a read's wait phase aborts it
        issue(0, 1'b0, 16'h0008, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_ren", mem_ren, 1);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_strobes", {mem_en, mem_ren, mem_wen}, 0);
        chk("mid_reset_busy", busy, 0);
        cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_reset_no_ack", cpu_ack, 0);
        end
        reset = 1'b0;
        exp_last[0] = '0; exp_last[1] = '0; done_last[0] = '0; done_last[1] = '0;
        shadow.delete();
        @(negedge clk);
        chk("post_reset_no_ack", cpu_ack, 0);
        // contention with both ports requesting continuously: CPU first, then alternate
        ack_order.delete();
        fork
            begin
                issue(0, 1'b1, 16'h0004, 32'hA1A1_0004, 1'b1); wait_ack(0);
                @(negedge clk);
                issue(0, 1'b0, 16'h0004, 32'h0, 1'b1); wait_ack(0);
            end
            begin
                issue(1, 1'b1, 16'h1804, 32'hB2B2_1804, 1'b1); wait_ack(1);
                @(negedge clk);
                issue(1, 1'b0, 16'h1804, 32'h0, 1'b1); wait_ack(1);
            end
        join
        @(negedge clk);
        exp_order = '{0, 1, 0, 1};
        chk("grant_count", ack_order.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < ack_order.size()) chk($sformatf("grant_order_%0d", i), ack_order[i], exp_order[i]);
        run(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 16'h0010);
        run(1, 1'b0, 16'h189C, 32'h0, 16'h189C);
        run(0, 1'b0, 16'h0020, 32'h0, 16'h0030);
        // RD_LAT=1 instance: read acks in cycle 3
        c1_addr = 16'h0042;
        c1_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c1_ack && n < 20);
        chk("lat1_cycles", n, 3);
        chk("lat1_rdata", c1_rdata, 32'hC0DE_0042);
        c1_req = 1'b0;
        @(negedge clk);
        fork
            rand_port(0);
            rand_port(1);
        join
        repeat (3) @(negedge clk);
        chk("queues_drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
